// File: rtl/float_to_int_if.sv
// float_to_int_if: operand/result handshake bundle for float_to_int.
//   a          packed binary32 operand      (master -> slave)
//   in_valid   operand valid                (master -> slave)
//   in_ready   converter can take operand   (slave  -> master)
//   z          signed int32 result          (slave  -> master)
//   overflow   result saturated             (slave  -> master)
//   nan        operand was NaN              (slave  -> master)
//   out_valid  z/overflow/nan valid         (slave  -> master)
//   out_ready  consumer accepts result      (master -> slave)
interface float_to_int_if;
    logic [31:0] a;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] z;
    logic        overflow;
    logic        nan;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output a, in_valid, out_ready,
        input  in_ready, z, overflow, nan, out_valid
    );

    modport slave (
        input  a, in_valid, out_ready,
        output in_ready, z, overflow, nan, out_valid
    );
endinterface

// File: rtl/float_to_int.sv
// float_to_int: sequential IEEE-754 binary32 -> signed int32 converter.
// Truncates toward zero and saturates out-of-range values and infinities;
// NaN yields 0x80000000 with the nan flag. Mantissa alignment uses a
// one-bit-per-cycle shifter, so latency is 2 + |exp-150| cycles for
// ordinary in-range operands and 2 cycles for everything else.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    float_to_int_if.slave (a/in_valid/in_ready, z/overflow/nan/out_valid/out_ready)
module float_to_int (
    input logic            clk,
    input logic            rst_n,
    float_to_int_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, UNPACK, SHIFT, PACK, OUT} state_t;

    state_t      state, state_next;
    logic        s_q;
    logic [7:0]  e_q;
    logic [31:0] m_q;
    logic        dir_left_q;
    logic [4:0]  cnt_q;
    logic        ovf_pend, nan_pend;
    logic [31:0] z_q;
    logic        ovf_q, nan_q;

    logic        exp_max, too_big, too_small, frac_zero, min_int, special;
    logic        shift_left;
    logic [4:0]  count_init;

    always_comb begin
        exp_max    = (e_q == 8'hFF);
        frac_zero  = (m_q[22:0] == '0);
        too_big    = (e_q >= 8'd158);
        too_small  = (e_q < 8'd127);
        min_int    = s_q && (e_q == 8'd158) && frac_zero;
        special    = exp_max || too_big || too_small;
        shift_left = (e_q > 8'd150);
        // |e-150| is at most 23 here, so the 5-bit modular difference
        // (150 mod 32 = 22) is exact.
        count_init = shift_left ? (e_q[4:0] - 5'd22) : (5'd22 - e_q[4:0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.in_valid) state_next = UNPACK;
            UNPACK:  if (special || count_init == '0) state_next = PACK;
                     else                              state_next = SHIFT;
            SHIFT:   if (cnt_q == 5'd1) state_next = PACK;
            PACK:    state_next = OUT;
            OUT:     if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q        <= 1'b0;
            e_q        <= '0;
            m_q        <= '0;
            dir_left_q <= 1'b0;
            cnt_q      <= '0;
            ovf_pend   <= 1'b0;
            nan_pend   <= 1'b0;
            z_q        <= '0;
            ovf_q      <= 1'b0;
            nan_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    s_q      <= bus.a[31];
                    e_q      <= bus.a[30:23];
                    m_q      <= {8'h00, 1'b1, bus.a[22:0]};
                    ovf_pend <= 1'b0;
                    nan_pend <= 1'b0;
                    ovf_q    <= 1'b0;
                    nan_q    <= 1'b0;
                end
                UNPACK: begin
                    // Special cases park their final bit pattern in m_q with
                    // the sign cleared so PACK passes it through unchanged.
                    if (exp_max && !frac_zero) begin
                        m_q      <= 32'h8000_0000;
                        s_q      <= 1'b0;
                        nan_pend <= 1'b1;
                    end else if (exp_max || too_big) begin
                        m_q      <= s_q ? 32'h8000_0000 : 32'h7FFF_FFFF;
                        s_q      <= 1'b0;
                        ovf_pend <= !min_int;
                    end else if (too_small) begin
                        m_q <= '0;
                    end else begin
                        dir_left_q <= shift_left;
                        cnt_q      <= count_init;
                    end
                end
                SHIFT: begin
                    m_q   <= dir_left_q ? {m_q[30:0], 1'b0} : {1'b0, m_q[31:1]};
                    cnt_q <= cnt_q - 5'd1;
                end
                PACK: begin
                    z_q   <= s_q ? (~m_q + 32'd1) : m_q;
                    ovf_q <= ovf_pend;
                    nan_q <= nan_pend;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == OUT);
    assign bus.z         = z_q;
    assign bus.overflow  = ovf_q;
    assign bus.nan       = nan_q;

endmodule

// File: tb/tb_float_to_int.sv
// tb_float_to_int: self-checking bench for float_to_int. Expected results come
// from a real-arithmetic model of binary32 -> int32 truncation/saturation.
module tb_float_to_int;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_bad;

    float_to_int_if bus ();

    float_to_int dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: value = 1.frac * 2^(e-127), truncated toward zero, saturated.
    task automatic ref_conv(input logic [31:0] x, output logic [31:0] ez,
                            output logic eo, output logic en, output int elat);
        int   e;
        real  r;
        logic [22:0] f;
        e  = int'(x[30:23]);
        f  = x[22:0];
        eo = 1'b0;
        en = 1'b0;
        elat = 2;
        if (e == 255 && f != 0) begin
            ez = 32'h8000_0000;
            en = 1'b1;
        end else if (e == 255) begin
            ez = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            eo = 1'b1;
        end else begin
            if (e < 127) r = 0.0;
            else begin
                r = 1.0 + real'(int'(f)) / 8388608.0;
                for (int i = 0; i < e - 127; i++) r = r * 2.0;
            end
            if (x[31]) r = -r;
            if (r >= 2147483648.0) begin
                ez = 32'h7FFF_FFFF;
                eo = 1'b1;
            end else if (r < -2147483648.0) begin
                ez = 32'h8000_0000;
                eo = 1'b1;
            end else if (r == -2147483648.0) begin
                ez = 32'h8000_0000;
            end else begin
                ez = $rtoi(r);
            end
            if (e >= 127 && e <= 157) elat = 2 + ((e > 150) ? e - 150 : 150 - e);
        end
    endtask

    // One conversion; hold = cycles of backpressure; during the hold the next
    // operand (nxt) may be presented with in_valid high.
    task automatic do_conv(input logic [31:0] val, input int hold,
                           input bit preload, input logic [31:0] nxt);
        logic [31:0] ez;
        logic        eo, en;
        int          elat, cyc, w;
        ref_conv(val, ez, eo, en, elat);
        w = 0;
        while (!bus.in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("in_ready_idle", 32'(bus.in_ready), 32'd1);
        bus.a = val;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("in_ready_busy", 32'(bus.in_ready), 32'd0);
        cyc = 0;
        while (!bus.out_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check($sformatf("latency a=%08h", val), 32'(cyc), 32'(elat));
        check($sformatf("z a=%08h", val), bus.z, ez);
        check($sformatf("overflow a=%08h", val), 32'(bus.overflow), 32'(eo));
        check($sformatf("nan a=%08h", val), 32'(bus.nan), 32'(en));
        if (preload) begin
            bus.a = nxt;
            bus.in_valid = 1'b1;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_z", bus.z, ez);
            check("hold_out_valid", 32'(bus.out_valid), 32'd1);
            check("hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("out_valid_drop", 32'(bus.out_valid), 32'd0);
        check("in_ready_after", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic reset_mid_shift();
        bus.a = 32'h3F80_0000;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_z", bus.z, 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (bus.out_valid) check("no_output_after_reset", 32'(bus.out_valid), 32'd0);
        end
        n_vec++;
    endtask

    logic [31:0] dir_vals [11] = '{
        32'h3F80_0000, 32'hC020_0000, 32'h3F00_0000, 32'h4F00_0000,
        32'hCF00_0000, 32'hFF80_0000, 32'h7FC0_0000, 32'h4B00_0000,
        32'h8000_0000, 32'h7F80_0000, 32'hCF00_0001
    };

    initial begin
        logic [31:0] v;
        n_vec = 0;
        n_bad = 0;
        rst_n = 1'b0;
        bus.a = '0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_z", bus.z, 32'd0);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_overflow", 32'(bus.overflow), 32'd0);
        check("reset_nan", 32'(bus.nan), 32'd0);
        check("reset_in_ready", 32'(bus.in_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (dir_vals[i]) do_conv(dir_vals[i], 0, 1'b0, '0);

        do_conv(32'h4120_0000, 10, 1'b1, 32'h4049_0FDB);
        do_conv(32'h4049_0FDB, 2, 1'b0, '0);

        reset_mid_shift();
        do_conv(32'h4120_0000, 0, 1'b0, '0);

        for (int n = 0; n < 300; n++) begin
            v = $urandom;
            if ($urandom_range(0, 3) != 0) v[30:23] = 8'($urandom_range(118, 162));
            else if ($urandom_range(0, 3) == 0) v[30:23] = 8'hFF;
            do_conv(v, int'($urandom_range(0, 3)), 1'b0, '0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
